// File: rtl/fp_align_add_if.sv
// Operand/result handshake bundle for the single-precision add/sub alignment front end.
`timescale 1ns/1ps
interface fp_align_add_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [24:0] out_mantissa_temp;
  logic [7:0]  out_exp;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out_sign, out_mantissa_temp, out_exp
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out_sign, out_mantissa_temp, out_exp
  );
endinterface

// File: rtl/fp_align_add.sv
// Three-stage FP32 add/sub front end: compare/swap, align, significand add/sub.
// Produces an un-normalized 25-bit significand for the normalizer.
`timescale 1ns/1ps
module fp_align_add (
  input  logic          clk,
  input  logic          rst,
  fp_align_add_if.slave bus
);
  localparam int STAGES = 3;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] l_sig;
    logic [23:0] s_sig;
    logic        eff_sub;
    logic [7:0]  d;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] l_sig;
    logic [23:0] s_al;
    logic        eff_sub;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic [STAGES:1] adv;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic            out_sign_q;
  logic [24:0]     out_mant_q;
  logic [7:0]      out_exp_q;

  // Each stage advances when it is empty or the stage after it advances.
  assign adv[3] = bus.out_ready | ~vld_pipe[3];
  assign adv[2] = adv[3] | ~vld_pipe[2];
  assign adv[1] = adv[2] | ~vld_pipe[1];

  assign bus.in_ready          = adv[1];
  assign bus.out_valid         = vld_pipe[3];
  assign bus.out_sign          = out_sign_q;
  assign bus.out_mantissa_temp = out_mant_q;
  assign bus.out_exp           = out_exp_q;

  // Stage 1: magnitude order on {exp, frac}; ties keep A as the larger.
  logic [7:0]  exp_a, exp_b;
  logic [23:0] sig_a, sig_b;
  logic        sign_b, a_ge;

  assign exp_a  = bus.a[30:23];
  assign exp_b  = bus.b[30:23];
  assign sig_a  = {|exp_a, bus.a[22:0]};
  assign sig_b  = {|exp_b, bus.b[22:0]};
  assign sign_b = bus.b[31] ^ bus.op;
  assign a_ge   = bus.a[30:0] >= bus.b[30:0];

  always_comb begin
    s1_d         = '0;
    s1_d.eff_sub = bus.a[31] ^ sign_b;
    if (a_ge) begin
      s1_d.sign  = bus.a[31];
      s1_d.exp   = exp_a;
      s1_d.l_sig = sig_a;
      s1_d.s_sig = sig_b;
      s1_d.d     = exp_a - exp_b;
    end else begin
      s1_d.sign  = sign_b;
      s1_d.exp   = exp_b;
      s1_d.l_sig = sig_b;
      s1_d.s_sig = sig_a;
      s1_d.d     = exp_b - exp_a;
    end
  end

  // Stage 2: truncating right shift; anything at or past 24 places vanishes.
  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.exp     = s1_q.exp;
    s2_d.l_sig   = s1_q.l_sig;
    s2_d.eff_sub = s1_q.eff_sub;
    s2_d.s_al    = (s1_q.d >= 8'd24) ? 24'd0 : (s1_q.s_sig >> s1_q.d);
  end

  // Stage 3: L >= S_al always, so subtraction never borrows.
  logic [24:0] sum;
  assign sum = s2_q.eff_sub ? ({1'b0, s2_q.l_sig} - {1'b0, s2_q.s_al})
                            : ({1'b0, s2_q.l_sig} + {1'b0, s2_q.s_al});

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      if (adv[1]) vld_pipe[1] <= bus.in_valid;
      if (adv[2]) vld_pipe[2] <= vld_pipe[1];
      if (adv[3]) vld_pipe[3] <= vld_pipe[2];
    end
  end

  always_ff @(posedge clk) begin
    if (adv[1]) s1_q <= s1_d;
    if (adv[2]) s2_q <= s2_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sign_q <= 1'b0;
      out_mant_q <= '0;
      out_exp_q  <= '0;
    end else if (adv[3]) begin
      out_sign_q <= (sum == 25'd0) ? 1'b0 : s2_q.sign;
      out_mant_q <= sum;
      out_exp_q  <= s2_q.exp;
    end
  end
endmodule

// File: tb/tb_fp_align_add.sv
// Scoreboard bench for fp_align_add: directed cases, back-pressure stream, mid-stream reset.
`timescale 1ns/1ps
module tb_fp_align_add;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_align_add_if dut_if ();
  fp_align_add u_dut (.clk(clk), .rst(rst), .bus(dut_if.slave));

  int n_chk = 0, n_err = 0, n_push = 0, n_pop = 0;
  logic [33:0] sb[$];
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {sign, mant[24:0], exp[7:0]} computed with plain integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
    int ea, eb, ma, mb, ml, ms, el, d, r;
    logic sa, sbb, sl;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = int'(a[22:0]) + ((ea != 0) ? 32'h800000 : 0);
    mb = int'(b[22:0]) + ((eb != 0) ? 32'h800000 : 0);
    sa = a[31]; sbb = b[31] ^ op;
    if (a[30:0] >= b[30:0]) begin ml = ma; ms = mb; el = ea; sl = sa; d = ea - eb; end
    else                    begin ml = mb; ms = ma; el = eb; sl = sbb; d = eb - ea; end
    if (d >= 24) ms = 0; else ms = ms / (1 << d);
    r = (sa != sbb) ? ml - ms : ml + ms;
    if (r == 0) sl = 1'b0;
    model = {sl, r[24:0], el[7:0]};
  endfunction

  // Handshakes are evaluated mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", {dut_if.out_sign, dut_if.out_mantissa_temp, dut_if.out_exp}, prev_out);
      if (dut_if.out_valid && dut_if.out_ready) begin
        n_pop++;
        if (sb.size() == 0) chk("spurious_out", 1, 0);
        else begin
          logic [33:0] e;
          e = sb.pop_front();
          chk("sb_sign", dut_if.out_sign, e[33]);
          chk("sb_mant", dut_if.out_mantissa_temp, e[32:8]);
          chk("sb_exp",  dut_if.out_exp, e[7:0]);
        end
      end
      if (dut_if.in_valid && dut_if.in_ready) begin
        sb.push_back(model(dut_if.a, dut_if.b, dut_if.op));
        n_push++;
      end
      prev_stall = dut_if.out_valid && !dut_if.out_ready;
      prev_out   = {dut_if.out_sign, dut_if.out_mantissa_temp, dut_if.out_exp};
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op);
    int t;
    dut_if.a = a; dut_if.b = b; dut_if.op = op; dut_if.in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (dut_if.in_ready) break;
      t++;
      if (t > 50) begin chk("send_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    dut_if.in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic s, input logic [24:0] m, input logic [7:0] e);
    dut_if.out_ready = 1'b1;
    send(a, b, op);
    chk({tag, "_early"}, dut_if.out_valid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({tag, "_valid"}, dut_if.out_valid, 1);
    chk({tag, "_mant"}, dut_if.out_mantissa_temp, m);
    chk({tag, "_exp"}, dut_if.out_exp, e);
    chk({tag, "_sign"}, dut_if.out_sign, s);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [5:0] pat;
    int         pops0, t;
    pat = 6'b101001;
    rst = 1'b1;
    dut_if.in_valid = 1'b0; dut_if.a = '0; dut_if.b = '0; dut_if.op = 1'b0;
    dut_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", dut_if.out_valid, 0);
    chk("rst_in_ready", dut_if.in_ready, 1);
    chk("rst_mant", dut_if.out_mantissa_temp, 0);
    chk("rst_exp", dut_if.out_exp, 0);
    chk("rst_sign", dut_if.out_sign, 0);

    directed("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 25'h1000000, 8'h7F);
    directed("three_minus_one", 32'h40400000, 32'h3F800000, 1'b1, 1'b0, 25'h0800000, 8'h80);
    directed("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 25'h0000000, 8'h7F);
    directed("neg1_plus_half", 32'hBF800000, 32'h3F000000, 1'b0, 1'b1, 25'h0400000, 8'h7F);
    directed("large_shift", 32'h4E800000, 32'h3F800000, 1'b0, 1'b0, 25'h0800000, 8'h9D);
    directed("b_larger_sub", 32'h3F800000, 32'h40400000, 1'b1, 1'b1, 25'h0800000, 8'h80);

    // Back-pressure stream with out_ready cycling 1,0,0,1,0,1.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] ra, rb;
          ra = $urandom;
          rb = {1'($urandom), 8'(ra[30:23] + 8'($urandom_range(0, 30)) - 8'd15), 23'($urandom)};
          send(ra, rb, 1'($urandom));
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          dut_if.out_ready = pat[i % 6];
          @(posedge clk); #1;
        end
        dut_if.out_ready = 1'b1;
      end
    join
    t = 0;
    while (sb.size() != 0 && t < 30) begin @(posedge clk); #1; t++; end
    chk("drain_empty", sb.size(), 0);
    chk("push_pop_count", n_pop, n_push);

    // Fill all three stages against a stalled output, then reset.
    dut_if.out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0);
    send(32'h40400000, 32'h3F800000, 1'b0);
    chk("in_ready_two_held", dut_if.in_ready, 1);
    send(32'h40800000, 32'h3F800000, 1'b1);
    chk("in_ready_full", dut_if.in_ready, 0);
    chk("out_valid_full", dut_if.out_valid, 1);
    dut_if.out_ready = 1'b1;
    #0;
    chk("in_ready_comb", dut_if.in_ready, 1);
    dut_if.out_ready = 1'b0;
    pops0 = n_pop;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", dut_if.out_valid, 0);
    chk("midrst_in_ready", dut_if.in_ready, 1);
    dut_if.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_emit", n_pop - pops0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fp_align_add.md
# fp_align_add

Three-stage pipelined IEEE-754 single-precision add/subtract front end. It unpacks two operands, orders them by magnitude, aligns the smaller one, and adds or subtracts the significands. It produces the un-normalized 25-bit significand, the 8-bit exponent and the sign, which feed `fp_normalizer` directly. Valid/ready handshakes on both sides allow back-pressure from the normalize/round stages.

## Interface
Parameters: none.

Ports:
- `clk` — in, 1 — system clock; all state updates on the rising edge.
- `rst` — in, 1 — synchronous, active-high reset.
- `in_valid` — in, 1 — `a`, `b` and `op` are valid this cycle.
- `in_ready` — out, 1 — stage 1 can accept an operand pair.
- `a` — in, 32 — operand A, IEEE-754 single precision.
- `b` — in, 32 — operand B, IEEE-754 single precision.
- `op` — in, 1 — 0 computes a+b; 1 computes a−b.
- `out_valid` — out, 1 — result present in stage 3.
- `out_ready` — in, 1 — downstream accepts the result.
- `out_sign` — out, 1 — result sign.
- `out_mantissa_temp` — out, 25 — bit 24 is the carry, bit 23 the hidden-bit position, bits 22:0 the fraction.
- `out_exp` — out, 8 — exponent of the larger operand (biased).

## Operation
- Unpack each operand into sign, exponent `e` and 24-bit significand `{e!=0, frac}`.
  - exp==0 gives a hidden bit of 0.
  - Inf/NaN get no special handling; exponent 255 is treated arithmetically.
- Effective operation: `eff_sub = a[31] ^ b[31] ^ op`. Operand B's sign is taken as `b[31]^op`.
- **Stage 1 (compare/swap):**
  - L = larger magnitude by comparing `{e, frac}`; S = the other operand.
  - On a tie, L = A.
  - Register L's sign, L's exponent, both significands, `eff_sub`, and `d = eL − eS` (8-bit unsigned, 0..255).
- **Stage 2 (align):**
  - `S_al = S_sig >> d`; if d ≥ 24, `S_al = 0`.
  - Shifted-out bits are discarded (truncation; no guard/sticky bits).
- **Stage 3 (add/sub):** zero-extend both values to 25 bits.
  - Add: `L_sig + S_al`, which may set bit 24.
  - Subtract: `L_sig − S_al`, which is always ≥ 0, so bit 24 = 0.
  - `out_exp` = eL.
  - `out_sign` = L's sign, except an exact zero result forces `out_sign` = 0.
- **Pipeline control:** each stage k holds a valid bit `vk`.
  - `adv3 = out_ready | ~v3`
  - `adv2 = adv3 | ~v2`
  - `adv1 = adv2 | ~v1`
  - `in_ready = adv1`. This is combinational from `out_ready` (no skid buffer).
  - Stage k loads from stage k−1 when `adv_k`; its valid becomes the upstream valid. Otherwise it holds.
  - `out_valid = v3`. Output data is stable while `out_valid & ~out_ready`.
- A transfer occurs only on `valid & ready` at a clock edge. Operands offered with `in_valid=1, in_ready=0` are not captured.

## Timing
- Latency: 3 cycles from an input handshake to `out_valid`, with no stalls.
- Throughput: 1 result/cycle while `out_ready=1`.
- Reset: `v1`, `v2`, `v3` = 0.
  - `out_valid` = 0, `out_sign` = 0, `out_mantissa_temp` = 0, `out_exp` = 0.
  - `in_ready` = 1 in the cycle after reset.
- Reset mid-operation: all in-flight items are dropped. No result emerges for any pair accepted before reset.
- Full pipeline with `out_ready=0`: all three stages hold and `in_ready=0`.
- When `out_ready` returns to 1, `in_ready=1` in the same cycle, and a new item may enter while stage 3 drains.
- Bubbles: an empty stage is filled even while a later stage stalls, so up to 3 items are buffered.
- `in_valid` and `out_ready` may toggle every cycle. Simultaneous accept and emit is legal and loses no data.

## Test plan
- **1.0 + 1.0** (a=0x3F800000, b=0x3F800000, op=0) → 3 cycles later `out_mantissa_temp=0x1000000`, `out_exp=0x7F`, `out_sign=0`.
- **3.0 − 1.0** (a=0x40400000, b=0x3F800000, op=1) → `0x0800000`, exp `0x80`, sign 0.
- **1.0 − 1.0** → mantissa 0, sign 0.
- **−1.0 + 0.5** (a=0xBF800000, b=0x3F000000, op=0) → `0x0400000`, exp `0x7F`, sign 1.
- **Large shift:** 2^30 + 1.0 (a=0x4E800000, b=0x3F800000) → d=30, S aligned to 0, `0x0800000`, exp `0x9D`.
- **Back-pressure:**
  - Stream 8 random pairs with `out_ready` following the pattern 1,0,0,1,0,1…
  - Results must appear in order and match a reference model, with none lost or duplicated.
  - `in_ready` must fall on the cycle the third item stalls.
- **Reset mid-stream:** with 3 items in flight, assert `rst` for 1 cycle → `out_valid=0` next cycle, `in_ready=1`, and none of the 3 items emerge.
